// File: rtl/bcd_to_binary.sv
// Packed-BCD to binary converter using reverse double-dabble, one FSM state per clock.
// Flags an invalid digit immediately and reports overflow when the value exceeds OUTPUT_WIDTH bits.
module bcd_to_binary #(
  parameter int DECIMAL_DIGITS = 2,
  parameter int OUTPUT_WIDTH   = 7
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
  input  logic                        i_Start,
  output logic [OUTPUT_WIDTH-1:0]     o_Binary,
  output logic                        o_DV,
  output logic                        o_Error,
  output logic                        o_Overflow,
  output logic                        o_Busy
);

  localparam int unsigned BCD_W  = DECIMAL_DIGITS * 4;
  localparam int unsigned IDX_W  = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
  localparam int unsigned LOOP_W = 8;

  localparam logic [2:0] s_IDLE              = 3'd0;
  localparam logic [2:0] s_SHIFT             = 3'd1;
  localparam logic [2:0] s_CHECK_SHIFT_INDEX = 3'd2;
  localparam logic [2:0] s_ADJUST            = 3'd3;
  localparam logic [2:0] s_CHECK_DIGIT_INDEX = 3'd4;
  localparam logic [2:0] s_DONE              = 3'd5;

  logic [2:0]              r_state,  state_next;
  logic [BCD_W-1:0]        r_bcd,    bcd_next;
  logic [OUTPUT_WIDTH-1:0] r_binary, binary_next;
  logic [LOOP_W-1:0]       r_loop,   loop_next;
  logic [IDX_W-1:0]        r_idx,    idx_next;
  logic                    r_error,  error_next;
  logic [OUTPUT_WIDTH-1:0] out_binary_next;
  logic                    dv_next, out_error_next, out_overflow_next;
  logic                    digit_bad_c;

  // Any input digit above 9 takes the error path.
  always_comb begin
    digit_bad_c = 1'b0;
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      if (i_BCD[d*4 +: 4] > 4'd9) digit_bad_c = 1'b1;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_next        = r_state;
    bcd_next          = r_bcd;
    binary_next       = r_binary;
    loop_next         = r_loop;
    idx_next          = r_idx;
    error_next        = r_error;
    dv_next           = 1'b0;
    out_binary_next   = o_Binary;
    out_error_next    = o_Error;
    out_overflow_next = o_Overflow;

    case (r_state)
      s_IDLE: begin
        if (i_Start) begin
          if (digit_bad_c) begin
            error_next  = 1'b1;
            binary_next = '0;
            bcd_next    = '0;
            state_next  = s_DONE;
          end else begin
            error_next  = 1'b0;
            bcd_next    = i_BCD;
            binary_next = '0;
            loop_next   = '0;
            idx_next    = '0;
            state_next  = s_SHIFT;
          end
        end
      end

      s_SHIFT: begin
        binary_next = {r_bcd[0], r_binary[OUTPUT_WIDTH-1:1]};
        bcd_next    = r_bcd >> 1;
        state_next  = s_CHECK_SHIFT_INDEX;
      end

      s_CHECK_SHIFT_INDEX: begin
        if (r_loop == LOOP_W'(OUTPUT_WIDTH - 1)) begin
          loop_next  = '0;
          state_next = s_DONE;
        end else begin
          loop_next  = r_loop + LOOP_W'(1);
          state_next = s_ADJUST;
        end
      end

      s_ADJUST: begin
        // Undo the decimal carry that the right shift pushed into the selected digit.
        for (int d = 0; d < DECIMAL_DIGITS; d++) begin
          if ((IDX_W'(d) == r_idx) && (r_bcd[d*4 +: 4] >= 4'd8)) begin
            bcd_next[d*4 +: 4] = r_bcd[d*4 +: 4] - 4'd3;
          end
        end
        state_next = s_CHECK_DIGIT_INDEX;
      end

      s_CHECK_DIGIT_INDEX: begin
        if (r_idx == IDX_W'(DECIMAL_DIGITS - 1)) begin
          idx_next   = '0;
          state_next = s_SHIFT;
        end else begin
          idx_next   = r_idx + IDX_W'(1);
          state_next = s_ADJUST;
        end
      end

      s_DONE: begin
        dv_next           = 1'b1;
        out_binary_next   = r_binary;
        out_error_next    = r_error;
        out_overflow_next = r_error ? 1'b0 : (|r_bcd);
        state_next        = s_IDLE;
      end

      default: state_next = s_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state    <= s_IDLE;
      r_bcd      <= '0;
      r_binary   <= '0;
      r_loop     <= '0;
      r_idx      <= '0;
      r_error    <= 1'b0;
      o_Binary   <= '0;
      o_DV       <= 1'b0;
      o_Error    <= 1'b0;
      o_Overflow <= 1'b0;
      o_Busy     <= 1'b0;
    end else begin
      r_state    <= state_next;
      r_bcd      <= bcd_next;
      r_binary   <= binary_next;
      r_loop     <= loop_next;
      r_idx      <= idx_next;
      r_error    <= error_next;
      o_Binary   <= out_binary_next;
      o_DV       <= dv_next;
      o_Error    <= out_error_next;
      o_Overflow <= out_overflow_next;
      o_Busy     <= (state_next != s_IDLE);
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: default 2-digit/7-bit instance plus a 6-bit output instance.
module tb_bcd_to_binary;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic [7:0] bcd_a = '0, bcd_b = '0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [6:0] bin_a;
  logic [5:0] bin_b;
  logic       dv_a, err_a, ovf_a, busy_a;
  logic       dv_b, err_b, ovf_b, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 i_Clock = ~i_Clock;

  bcd_to_binary dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_BCD(bcd_a), .i_Start(start_a),
    .o_Binary(bin_a), .o_DV(dv_a), .o_Error(err_a), .o_Overflow(ovf_a), .o_Busy(busy_a)
  );

  bcd_to_binary #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(6)) dut6 (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_BCD(bcd_b), .i_Start(start_b),
    .o_Binary(bin_b), .o_DV(dv_b), .o_Error(err_b), .o_Overflow(ovf_b), .o_Busy(busy_b)
  );

  // Pulse start for one sampling edge; returns #1 after that edge.
  task automatic start_conv(input bit six, input logic [7:0] v);
    @(negedge i_Clock);
    if (six) begin bcd_b = v; start_b = 1'b1; end
    else     begin bcd_a = v; start_a = 1'b1; end
    @(posedge i_Clock);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Edges from the previous edge until o_DV is seen high; -1 if the budget runs out.
  task automatic wait_dv(input bit six, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge i_Clock);
      #1;
      if ((six ? dv_b : dv_a) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_Clock);
    #1;
    checks++;
    if ({bin_a, dv_a, err_a, ovf_a, busy_a} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {bin_a, dv_a, err_a, ovf_a, busy_a});
    end
    checks++;
    if ({bin_b, dv_b, err_b, ovf_b, busy_b} !== 10'd0) begin
      errors++; $display("FAIL reset_outputs6 got %b want 0", {bin_b, dv_b, err_b, ovf_b, busy_b});
    end
    @(negedge i_Clock);
    i_Reset = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    start_conv(1'b0, 8'h42);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy_a); end
    wait_dv(1'b0, n);
    checks++;
    if (n != 39) begin errors++; $display("FAIL latency_42 got %0d want 39", n); end
    checks++;
    if ({bin_a, err_a, ovf_a, busy_a} !== {7'd42, 3'b000}) begin
      errors++; $display("FAIL result_42 got bin=%0d err=%b ovf=%b busy=%b want 42 0 0 0", bin_a, err_a, ovf_a, busy_a);
    end
    @(posedge i_Clock);
    #1;
    checks++;
    if (dv_a !== 1'b0 || bin_a !== 7'd42) begin
      errors++; $display("FAIL dv_single_cycle got dv=%b bin=%0d want 0 42", dv_a, bin_a);
    end
  endtask

  task automatic test_edges();
    int n;
    start_conv(1'b0, 8'h99);
    wait_dv(1'b0, n);
    checks++;
    if (n != 39 || {bin_a, err_a, ovf_a} !== {7'd99, 2'b00}) begin
      errors++; $display("FAIL result_99 got n=%0d bin=%0d err=%b ovf=%b want 39 99 0 0", n, bin_a, err_a, ovf_a);
    end
    start_conv(1'b0, 8'h00);
    wait_dv(1'b0, n);
    checks++;
    if (n != 39 || {bin_a, err_a, ovf_a} !== {7'd0, 2'b00}) begin
      errors++; $display("FAIL result_00 got n=%0d bin=%0d err=%b ovf=%b want 39 0 0 0", n, bin_a, err_a, ovf_a);
    end
  endtask

  task automatic test_sweep();
    int n;
    logic [7:0] v;
    logic [6:0] exp;
    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        v   = 8'(t * 16 + o);
        exp = 7'(t * 10 + o);
        start_conv(1'b0, v);
        wait_dv(1'b0, n);
        checks++;
        if (n != 39 || {bin_a, err_a, ovf_a} !== {exp, 2'b00}) begin
          errors++;
          $display("FAIL sweep_%h got n=%0d bin=%0d err=%b ovf=%b want 39 %0d 0 0", v, n, bin_a, err_a, ovf_a, exp);
        end
      end
    end
  endtask

  task automatic test_error();
    int n;
    start_conv(1'b0, 8'h3A);
    wait_dv(1'b0, n);
    checks++;
    if (n != 1 || {bin_a, err_a, ovf_a} !== {7'd0, 2'b10}) begin
      errors++; $display("FAIL error_3A got n=%0d bin=%0d err=%b ovf=%b want 1 0 1 0", n, bin_a, err_a, ovf_a);
    end
    @(posedge i_Clock);
    #1;
    checks++;
    if (dv_a !== 1'b0 || err_a !== 1'b1) begin
      errors++; $display("FAIL error_held got dv=%b err=%b want 0 1", dv_a, err_a);
    end
    start_conv(1'b0, 8'hA0);
    wait_dv(1'b0, n);
    checks++;
    if (n != 1 || {bin_a, err_a, ovf_a} !== {7'd0, 2'b10}) begin
      errors++; $display("FAIL error_A0 got n=%0d bin=%0d err=%b ovf=%b want 1 0 1 0", n, bin_a, err_a, ovf_a);
    end
  endtask

  task automatic test_overflow();
    int n;
    start_conv(1'b1, 8'h99);
    wait_dv(1'b1, n);
    checks++;
    if (n != 33 || {bin_b, err_b, ovf_b} !== {6'd35, 2'b01}) begin
      errors++; $display("FAIL ovf_99 got n=%0d bin=%0d err=%b ovf=%b want 33 35 0 1", n, bin_b, err_b, ovf_b);
    end
    start_conv(1'b1, 8'h63);
    wait_dv(1'b1, n);
    checks++;
    if (n != 33 || {bin_b, err_b, ovf_b} !== {6'd63, 2'b00}) begin
      errors++; $display("FAIL ovf_63 got n=%0d bin=%0d err=%b ovf=%b want 33 63 0 0", n, bin_b, err_b, ovf_b);
    end
    start_conv(1'b1, 8'h64);
    wait_dv(1'b1, n);
    checks++;
    if (n != 33 || {bin_b, err_b, ovf_b} !== {6'd0, 2'b01}) begin
      errors++; $display("FAIL ovf_64 got n=%0d bin=%0d err=%b ovf=%b want 33 0 0 1", n, bin_b, err_b, ovf_b);
    end
  endtask

  task automatic test_restart_ignored();
    int n;
    int extra;
    start_conv(1'b0, 8'h42);
    repeat (9) @(posedge i_Clock);
    start_conv(1'b0, 8'h17);
    wait_dv(1'b0, n);
    checks++;
    if (n != 29 || bin_a !== 7'd42) begin
      errors++; $display("FAIL restart_ignored got n=%0d bin=%0d want 29 42", n, bin_a);
    end
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge i_Clock);
      #1;
      if (dv_a === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL restart_no_second_dv got extra=%0d busy=%b want 0 0", extra, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    @(negedge i_Clock);
    bcd_a = 8'h42;
    start_a = 1'b1;
    @(posedge i_Clock);
    wait_dv(1'b0, n1);
    wait_dv(1'b0, n2);
    start_a = 1'b0;
    checks++;
    if (n1 != 39 || n2 != 40 || bin_a !== 7'd42) begin
      errors++; $display("FAIL back_to_back got n1=%0d n2=%0d bin=%0d want 39 40 42", n1, n2, bin_a);
    end
    @(posedge i_Clock);
    #1;
    checks++;
    if (busy_a !== 1'b0 || dv_a !== 1'b0) begin
      errors++; $display("FAIL back_to_back_idle got busy=%b dv=%b want 0 0", busy_a, dv_a);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int extra;
    start_conv(1'b0, 8'h42);
    repeat (19) @(posedge i_Clock);
    @(negedge i_Clock);
    i_Reset = 1'b1;
    @(posedge i_Clock);
    #1;
    checks++;
    if ({bin_a, dv_a, err_a, ovf_a, busy_a} !== 11'd0) begin
      errors++; $display("FAIL reset_mid_outputs got %b want 0", {bin_a, dv_a, err_a, ovf_a, busy_a});
    end
    @(negedge i_Clock);
    i_Reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge i_Clock);
      #1;
      if (dv_a === 1'b1 || busy_a === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL reset_mid_abandoned got activity=%0d want 0", extra); end
    start_conv(1'b0, 8'h17);
    wait_dv(1'b0, n);
    checks++;
    if (n != 39 || {bin_a, err_a, ovf_a} !== {7'd17, 2'b00}) begin
      errors++; $display("FAIL after_reset_17 got n=%0d bin=%0d err=%b ovf=%b want 39 17 0 0", n, bin_a, err_a, ovf_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_error();
    test_sweep();
    test_overflow();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
